// File: rtl/detect_pkg.sv
// Shared types, default widths and config-legality check for the frame-level
// sequence detector.
package detect_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int LEN_W_DEF = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic cfg_ok(input int unsigned len, input int unsigned flen,
                                    input int unsigned pat_w);
        return (len >= 1) && (len <= pat_w) && (flen != 0);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial window shift register with a length-masked compare against the pattern.
// hit reflects the window as it will be after the current shift.
import detect_pkg::*;

module pattern_match_core #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    output logic             hit
);

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] window_nxt;
    logic [PAT_W-1:0] mask;

    assign window_nxt = {window[PAT_W-2:0], din};

    // Pattern bits at or above pat_len take no part in the compare.
    for (genvar g = 0; g < PAT_W; g++) begin : g_mask
        assign mask[g] = (pat_len > LEN_W'(g));
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            window <= '0;
        end else if (clr) begin
            window <= '0;
        end else if (shift_en) begin
            window <= window_nxt;
        end
    end

    assign hit = shift_en && (((window_nxt ^ pat) & mask) == '0);

endmodule

// File: rtl/detect_frame_ctrl.sv
// Frame controller for serial pattern detection. Optional abort input is enabled
// by DETECT_FRAME_ABORT_EN.  States: IDLE | wait for start, RUN | consume one
// din per cycle, DONE | one-cycle done pulse.
import detect_pkg::*;

module detect_frame_ctrl #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             din,
    output logic             din_req,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             err
`ifdef DETECT_FRAME_ABORT_EN
    ,
    input  logic             abort
`endif
);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] pat_len_q;
    logic [CNT_W-1:0] frame_len_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W:0]   bits_seen;
    logic             run, cfg_legal, accept, reject;
    logic             last_bit, hit, match_evt, abort_req;

`ifdef DETECT_FRAME_ABORT_EN
    assign abort_req = run && abort;
`else
    assign abort_req = 1'b0;
`endif

    assign run       = (state == ST_RUN);
    assign cfg_legal = cfg_ok(32'(pat_len), 32'(frame_len), PAT_W);
    assign accept    = (state == ST_IDLE) && start && cfg_legal;
    assign reject    = (state == ST_IDLE) && start && !cfg_legal;
    assign bits_seen = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign last_bit  = run && (bits_seen == {1'b0, frame_len_q});
    // The cleared window would otherwise match all-zero patterns early.
    assign match_evt = hit && (bits_seen >= (CNT_W+1)'(pat_len_q));

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .ck       (ck),
        .rst      (rst),
        .shift_en (run),
        .clr      (accept),
        .din      (din),
        .pat      (pat_q),
        .pat_len  (pat_len_q),
        .hit      (hit)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din_req   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                din_req = 1'b1;
                busy    = 1'b1;
                if (abort_req)     state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            pat_q       <= '0;
            pat_len_q   <= '0;
            frame_len_q <= '0;
            bit_cnt     <= '0;
            match_cnt   <= '0;
            match       <= 1'b0;
            err         <= 1'b0;
        end else begin
            err   <= reject;
            match <= match_evt;
            if (accept) begin
                pat_q       <= pat;
                pat_len_q   <= pat_len;
                frame_len_q <= frame_len;
                bit_cnt     <= '0;
                match_cnt   <= '0;
            end else if (run) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (match_evt) match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_detect_frame_ctrl.sv
// Directed, table-driven bench for detect_frame_ctrl; the abort sequence is only
// built when DETECT_FRAME_ABORT_EN is defined.
module tb_detect_frame_ctrl;

    typedef struct {
        logic [3:0]  pat;
        logic [2:0]  pat_len;
        logic [7:0]  frame_len;
        logic [15:0] din;
        logic [15:0] exp_match;
        logic [7:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    logic       ck = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pat;
    logic [2:0] pat_len;
    logic [7:0] frame_len;
    logic       din;
    logic       din_req, busy, match, done, err;
    logic [7:0] match_cnt;
    logic       abort;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] last_cnt;
    vec_t       vecs [9];

    detect_frame_ctrl dut (
        .ck        (ck),
        .rst       (rst),
        .start     (start),
        .pat       (pat),
        .pat_len   (pat_len),
        .frame_len (frame_len),
        .din       (din),
        .din_req   (din_req),
        .busy      (busy),
        .match     (match),
        .match_cnt (match_cnt),
        .done      (done),
        .err       (err)
`ifdef DETECT_FRAME_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        pat       = v.pat;
        pat_len   = v.pat_len;
        frame_len = v.frame_len;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (v.exp_err) begin
            chk1("err_pulse", err, 1'b1);
            chk1("err_busy", busy, 1'b0);
            chk1("err_din_req", din_req, 1'b0);
            chk8("err_cnt_hold", match_cnt, last_cnt);
            tick();
            chk1("err_one_cycle", err, 1'b0);
            chk1("err_busy_after", busy, 1'b0);
        end else begin
            chk1("run_busy", busy, 1'b1);
            chk1("run_din_req", din_req, 1'b1);
            chk1("run_err", err, 1'b0);
            for (int k = 0; k < int'(v.frame_len); k++) begin
                din = v.din[k];
                tick();
                chk1("match", match, v.exp_match[k]);
                chk1("done", done, k == int'(v.frame_len) - 1);
                chk1("din_req", din_req, k != int'(v.frame_len) - 1);
            end
            chk8("match_cnt", match_cnt, v.exp_cnt);
            tick();
            chk1("idle_done", done, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_match", match, 1'b0);
            chk8("idle_cnt_hold", match_cnt, v.exp_cnt);
            last_cnt = v.exp_cnt;
        end
    endtask

    initial begin
        logic [3:0] bits;
        logic [3:0] exp_m;

        //          pat      len   flen   din       exp_match cnt   err
        vecs[0] = '{4'b0111, 3'd3, 8'd7, 16'h001C, 16'h0010, 8'd1, 1'b0};
        vecs[1] = '{4'b0011, 3'd2, 8'd4, 16'h000F, 16'h000E, 8'd3, 1'b0};
        vecs[2] = '{4'b0001, 3'd0, 8'd4, 16'h0000, 16'h0000, 8'd0, 1'b1};
        vecs[3] = '{4'b1010, 3'd1, 8'd5, 16'h0009, 16'h0016, 8'd3, 1'b0};
        vecs[4] = '{4'b0001, 3'd5, 8'd4, 16'h0000, 16'h0000, 8'd0, 1'b1};
        vecs[5] = '{4'b0110, 3'd4, 8'd8, 16'h0036, 16'h0048, 8'd2, 1'b0};
        vecs[6] = '{4'b0011, 3'd2, 8'd0, 16'h0000, 16'h0000, 8'd0, 1'b1};
        vecs[7] = '{4'b1100, 3'd2, 8'd3, 16'h0000, 16'h0006, 8'd2, 1'b0};
        vecs[8] = '{4'b0001, 3'd1, 8'd1, 16'h0001, 16'h0001, 8'd1, 1'b0};

        rst = 1'b1; start = 1'b0; pat = '0; pat_len = '0; frame_len = '0;
        din = 1'b0; abort = 1'b0; last_cnt = '0;
        #1;
        chk1("rst_din_req", din_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_match", match, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk8("rst_cnt", match_cnt, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Restart and config change while running have no effect.
        bits  = 4'b1011;
        exp_m = 4'b0010;
        pat = 4'b0011; pat_len = 3'd2; frame_len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din = bits[k];
            if (k == 1) begin
                start = 1'b1; pat = 4'b0000; pat_len = 3'd1;
            end
            tick();
            chk1("busy_match", match, exp_m[k]);
            chk1("busy_err", err, 1'b0);
            chk1("busy_busy", busy, 1'b1);
        end
        chk1("busy_done", done, 1'b1);
        chk8("busy_cnt", match_cnt, 8'd1);
        pat_len = 3'd0;
        tick();
        start = 1'b0;
        chk1("done_start_busy", busy, 1'b0);
        chk1("done_start_err", err, 1'b0);
        chk8("done_start_cnt", match_cnt, 8'd1);
        tick();
        chk1("done_start_err2", err, 1'b0);
        chk1("done_start_busy2", busy, 1'b0);

        // Reset during the 3rd RUN cycle.
        pat = 4'b0001; pat_len = 3'd1; frame_len = 8'd8; din = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk1("pre_rst_match", match, 1'b1);
        chk8("pre_rst_cnt", match_cnt, 8'd2);
        rst = 1'b1;
        #1;
        chk1("mid_rst_din_req", din_req, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_match", match, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk8("mid_rst_cnt", match_cnt, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        chk1("post_rst_done", done, 1'b0);
        last_cnt = 8'd0;
        run_vec(vecs[0]);

`ifdef DETECT_FRAME_ABORT_EN
        pat = 4'b0001; pat_len = 3'd1; frame_len = 8'd6; din = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) abort = 1'b1;
            tick();
            chk1("abort_match", match, 1'b1);
        end
        abort = 1'b0;
        chk8("abort_cnt", match_cnt, 8'd3);
        chk1("abort_done", done, 1'b0);
        chk1("abort_din_req", din_req, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        tick();
        chk1("abort_idle_done", done, 1'b0);
        chk1("abort_idle_match", match, 1'b0);
        chk8("abort_idle_cnt", match_cnt, 8'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/detect_frame_ctrl.md
Name: detect_frame_ctrl

Overview:
- Frame-level controller for serial sequence detection: accepts a start command with a programmable pattern, pattern length and frame length, then requests one serial bit per cycle.
- Detects overlapping occurrences of the pattern, pulses on each match and counts matches.
- Signals completion with a done pulse.
- Sits between a host/config interface and a serial bit source; sequences and configures the detection datapath.

Parameters:
- PAT_W, 4, maximum pattern length in bits
- LEN_W, 3, width of pat_len (must hold PAT_W)
- CNT_W, 8, width of frame_len and match_cnt

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command; sampled in IDLE only
- pat  in  PAT_W  pattern; pat[0] = most recent bit, pat[pat_len-1] = oldest; captured on accepted start
- pat_len  in  LEN_W  pattern length, legal 1..PAT_W; captured on accepted start
- frame_len  in  CNT_W  bits per frame, legal 1..2^CNT_W-1; captured on accepted start
- din  in  1  serial bit, sampled on every edge where din_req=1
- din_req  out  1  high in RUN: controller consumes din this cycle
- busy  out  1  high in RUN and DONE
- match  out  1  one-cycle pulse per detected occurrence
- match_cnt  out  CNT_W  matches in current/last frame
- done  out  1  one-cycle pulse at end of frame
- err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0. Window, bit counter and config registers are cleared.
- States: IDLE, RUN, DONE. err is a registered pulse issued from IDLE; it has no separate state.
- IDLE, start=1 with a legal config:
  - Capture pat/pat_len/frame_len.
  - Clear the window, bit counter and match_cnt.
  - Next state RUN.
- IDLE, start=1 with pat_len=0, pat_len>PAT_W or frame_len=0: err=1 next cycle; stay IDLE; match_cnt unchanged.
- RUN: din_req=1 every cycle. On each edge:
  - window <= {window[PAT_W-2:0], din}.
  - bit_cnt <= bit_cnt+1.
- Match rule: the new window[pat_len-1:0] equals pat[pat_len-1:0], and bits sampled so far (including this one) >= pat_len. Then match=1 next cycle and match_cnt increments.
- Overlapping matches count. Bits of pat at or above pat_len are ignored.
- When the bit sampled is the frame_len-th bit, next state is DONE.
- DONE lasts one cycle:
  - done=1, din_req=0.
  - A match completed by the final bit appears in this same cycle, and match_cnt already includes it.
  - Next state IDLE.
- Latency: the first din is sampled on the edge after the start edge. done appears frame_len+1 cycles after the start edge.
- match_cnt holds its final value in IDLE until the next accepted start. It cannot overflow because matches <= frame_len <= 2^CNT_W-1.
- start in RUN or DONE is ignored (no err). start on the DONE cycle is also ignored.
- pat/pat_len/frame_len changes after capture have no effect on the running frame.
- Reset mid-RUN aborts immediately: no done, match_cnt is cleared.

Optional Feature:
- Macro DETECT_FRAME_ABORT_EN. When defined, adds input port abort (1 bit).
- abort=1 in RUN: next state IDLE, no done pulse, din_req drops next cycle, match_cnt holds its partial count. Ignored in IDLE/DONE.
- A match completed by the bit sampled on the abort edge is still pulsed and counted.
- When undefined, the port does not exist and behaviour is as above.

Decomposition:
- Package detect_pkg holds:
  - state encoding typedef (IDLE/RUN/DONE)
  - default PAT_W/LEN_W/CNT_W constants
  - a config-legality function (pat_len, frame_len -> ok)
- One natural sub-module, pattern_match_core: window shift register plus masked compare, with inputs shift_en, din, pat, pat_len, clr and output hit.
- The FSM, counters and handshake stay in detect_frame_ctrl.

Test Plan:
- Basic stream: pat=3'b111 (pat_len=3), frame_len=7, din=0,0,1,1,1,0,0 -> single match pulse on the cycle after the 5th bit; done 8 cycles after start; match_cnt=1.
- Overlap: pat=2'b11 (pat_len=2), frame_len=4, din=1,1,1,1 -> match pulses after bits 2, 3 and 4; the last pulse coincides with done; match_cnt=3.
- Illegal config:
  - start with pat_len=0 -> err=1 for one cycle, busy stays 0, din_req stays 0.
  - Repeat with pat_len=5 (PAT_W=4) and with frame_len=0 -> same response.
- Busy start and late config change: start asserted again mid-RUN, and pat changed mid-RUN -> no effect; the count matches the original pattern; no err.
- Reset mid-frame: rst=1 during the 3rd RUN cycle -> all outputs 0 immediately, state IDLE; a new start then runs a clean frame.
- With DETECT_FRAME_ABORT_EN: pat=1'b1 (pat_len=1), frame_len=6, din all 1, abort asserted with the 3rd bit -> 3 match pulses, match_cnt=3, no done, IDLE afterward.
